// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 stream multiplexer with valid/ready handshake.
// Selection is either a fixed external index or round-robin starting after the last grant.
module mux_nto1_rr #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] ptr_p0;
  logic [SEL_W-1:0] gnt;
  logic             gv;
  logic             load;
  logic [WIDTH-1:0] gnt_data;
  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] chan_p0;
  logic             vld_p0;

  assign load = ~vld_p0 | out_ready;

  // Round-robin: lowest valid index above ptr wins; otherwise wrap to lowest valid overall.
  always_comb begin
    gnt = '0;
    gv  = 1'b0;
    if (!mode) begin
      gnt = sel;
      for (int i = 0; i < CHANNELS; i++)
        if (sel == SEL_W'(i)) gv = in_valid[i];
    end else begin
      gv = |in_valid;
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (in_valid[i]) gnt = SEL_W'(i);
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (in_valid[i] && (SEL_W'(i) > ptr_p0)) gnt = SEL_W'(i);
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load & gv & ~rst;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      ptr_p0  <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (gv) begin
        vld_p0  <= 1'b1;
        data_p0 <= gnt_data;
        chan_p0 <= gnt;
        ptr_p0  <= gnt;
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign out_data  = data_p0;
  assign out_chan  = chan_p0;
  assign out_valid = vld_p0;

endmodule
